idma_irq_ctrl: RTL

//   Parametrised interrupt controller for multi-channel iDMA systems. Per channel it turns read-done
//   and write-done pulses into W1C pending bits, masks them with an enable register, and drives one

---
 rtl/idma_irq_ctrl_if.sv | 31 +++
 rtl/idma_irq_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/idma_irq_ctrl_if.sv
// ============================================================================
//  Module      : idma_irq_ctrl_if
//  Description : 64-bit register bus between the system wrapper (master) and
//                the iDMA interrupt controller (slave). Zero-wait handshake:
//                ready, rdata and error answer in the same cycle as valid.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface idma_irq_ctrl_if;
    logic        valid;
    logic        write;
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
    logic        ready;
    logic        error;

    modport master (
        output valid, write, addr, wdata, wstrb,
        input  rdata, ready, error
    );

    modport slave (
        input  valid, write, addr, wdata, wstrb,
        output rdata, ready, error
    );
endinterface

`default_nettype wire

// File: rtl/idma_irq_ctrl.sv
// ============================================================================
//  Module      : idma_irq_ctrl
//  Description : Interrupt controller for multi-channel iDMA. Read/write done
//                pulses set W1C pending bits (IPSR), masked by IER into one
//                interrupt line per source. Source 2c = channel c read,
//                source 2c+1 = channel c write.
//                Optional per-source event coalescing (count threshold plus
//                timeout) is built when IDMA_IRQ_COAL_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idma_irq_ctrl #(
    parameter int unsigned NumCh    = 1,
    parameter int unsigned CntWidth = 8,
    parameter int unsigned TmrWidth = 16
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_ni,
    input  wire logic [NumCh-1:0]     r_done_i,
    input  wire logic [NumCh-1:0]     w_done_i,
    idma_irq_ctrl_if.slave            reg_bus,
    output logic      [2*NumCh-1:0]   irq_o,
    output logic                      irq_any_o
);

    localparam int unsigned NUM_SRC = 2 * NumCh;

    // Register index = addr[5:3]
    localparam logic [2:0] IDX_IPSR    = 3'd0;
    localparam logic [2:0] IDX_IER     = 3'd1;
    localparam logic [2:0] IDX_THRESH  = 3'd2;
    localparam logic [2:0] IDX_TIMEOUT = 3'd3;
    localparam logic [2:0] IDX_STAT    = 3'd4;

    logic [NUM_SRC-1:0] ev;
    logic [NUM_SRC-1:0] set_pend;
    logic [NUM_SRC-1:0] stat;
    logic [NUM_SRC-1:0] ipsr;
    logic [NUM_SRC-1:0] ier;

    logic [2:0]  reg_idx;
    logic        addr_ok;
    logic        wr_en;
    logic [63:0] wmask;
    logic [63:0] wd;
    logic [63:0] rdata_mux;

    // ------------------------------------------------------------------
    // Event vector: interleave read/write done pulses per channel
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NumCh; c++) begin : g_ev
        assign ev[2*c]   = r_done_i[c];
        assign ev[2*c+1] = w_done_i[c];
    end

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign reg_idx = reg_bus.addr[5:3];
    assign addr_ok = (reg_bus.addr[2:0] == 3'd0) && (reg_idx <= IDX_STAT);
    assign wr_en   = reg_bus.valid && reg_bus.write && addr_ok;

    for (genvar b = 0; b < 8; b++) begin : g_wmask
        assign wmask[8*b +: 8] = {8{reg_bus.wstrb[b]}};
    end

    // Write data with disabled byte lanes forced to zero
    assign wd = reg_bus.wdata & wmask;

    assign reg_bus.ready = reg_bus.valid;
    assign reg_bus.error = reg_bus.valid && !addr_ok;

`ifdef IDMA_IRQ_COAL_EN
    logic [CntWidth-1:0] thresh;
    logic [TmrWidth-1:0] timeout;
    logic [CntWidth-1:0] thr_eff;

    // A stored threshold of 0 behaves as 1 (fire on every event)
    assign thr_eff = (thresh == '0) ? {{(CntWidth-1){1'b0}}, 1'b1} : thresh;

    // Threshold and timeout registers, byte-lane writable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            thresh  <= {{(CntWidth-1){1'b0}}, 1'b1};
            timeout <= '0;
        end else begin
            if (wr_en && (reg_idx == IDX_THRESH)) begin
                thresh <= (thresh & ~wmask[CntWidth-1:0]) | wd[CntWidth-1:0];
            end
            if (wr_en && (reg_idx == IDX_TIMEOUT)) begin
                timeout <= (timeout & ~wmask[TmrWidth-1:0]) | wd[TmrWidth-1:0];
            end
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_coal
        logic [CntWidth-1:0] cnt;
        logic [TmrWidth-1:0] tmr;
        logic [CntWidth:0]   cnt_sum;
        logic [TmrWidth:0]   tmr_inc;
        logic                hit_cnt;
        logic                hit_tmr;

        // One extra bit on sum/increment so comparisons see the true value
        assign cnt_sum = {1'b0, cnt} + {{CntWidth{1'b0}}, ev[s]};
        assign tmr_inc = {1'b0, tmr} + {{TmrWidth{1'b0}}, 1'b1};
        assign hit_cnt = cnt_sum >= {1'b0, thr_eff};
        assign hit_tmr = (timeout != '0) && (cnt != '0) && (tmr_inc >= {1'b0, timeout});

        assign set_pend[s] = hit_cnt || hit_tmr;
        assign stat[s]     = (cnt != '0);

        // Count events toward the threshold; the timer runs only while a batch is open
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt <= '0;
                tmr <= '0;
            end else if (hit_cnt) begin
                cnt <= '0;
                tmr <= '0;
            end else if (hit_tmr) begin
                // An event arriving with the timeout opens the next batch
                cnt <= {{(CntWidth-1){1'b0}}, ev[s]};
                tmr <= '0;
            end else begin
                cnt <= cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
                if (cnt_sum != '0) begin
                    tmr <= tmr_inc[TmrWidth] ? '1 : tmr_inc[TmrWidth-1:0];
                end else begin
                    tmr <= '0;
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^wd;
`else
    // Without coalescing every event sets its pending bit directly
    assign set_pend = ev;
    assign stat     = '0;

    logic unused_bits;
    assign unused_bits = ^{wd, CntWidth[0], TmrWidth[0]};
`endif

    // Pending (W1C, set wins over clear) and enable registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ipsr <= '0;
            ier  <= '0;
        end else begin
            ipsr <= (ipsr & ~((wr_en && (reg_idx == IDX_IPSR)) ? wd[NUM_SRC-1:0] : '0))
                  | set_pend;
            if (wr_en && (reg_idx == IDX_IER)) begin
                ier <= (ier & ~wmask[NUM_SRC-1:0]) | wd[NUM_SRC-1:0];
            end
        end
    end

    // Read data multiplexer; zero when idle or on an errored access
    always_comb begin
        rdata_mux = '0;
        case (reg_idx)
            IDX_IPSR:    rdata_mux = 64'(ipsr);
            IDX_IER:     rdata_mux = 64'(ier);
`ifdef IDMA_IRQ_COAL_EN
            IDX_THRESH:  rdata_mux = 64'(thresh);
            IDX_TIMEOUT: rdata_mux = 64'(timeout);
`endif
            IDX_STAT:    rdata_mux = 64'(stat);
            default:     rdata_mux = '0;
        endcase
    end

    assign reg_bus.rdata = (reg_bus.valid && addr_ok) ? rdata_mux : '0;

    assign irq_o     = ipsr & ier;
    assign irq_any_o = |irq_o;

endmodule

`default_nettype wire
